divisor_secuencial: RTL
=======================

// Module: divisor_secuencial
// PURPOSE
//  Multi-cycle unsigned restoring divider, N-bit dividend / N-bit divisor.
//  Sits directly downstream of the two's-complement negation stage.
//  Each trial subtraction is an add of the negated divisor: R + (~D + 1).
//  Start/done handshake; one quotient bit resolved per clock.
// PARAMETERS
//  N  default 4  operand width in bits (N >= 2)
// PORTS
//  clk            in   1   system clock, rising edge
//  rst_n          in   1   asynchronous active-low reset
//  start          in   1   request; sampled only when busy=0
//  dividendo      in   N   dividend, captured on accepted start
//  divisor        in   N   divisor, captured on accepted start
//  busy           out  1   high from the accepted start until done
//  done           out  1   one-cycle pulse, result valid
//  cociente       out  N   quotient, held until next accepted start
//  residuo        out  N   remainder, held until next accepted start
//  div_cero       out  1   divisor was 0; held with the result
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; busy, done, div_cero=0;
//   cociente, residuo=0; internal registers cleared.
//   Reset mid-operation aborts and discards the operation.
//  States: IDLE -> CALC -> DONE -> IDLE.
//  IDLE:
//   - start=1 at edge k: latch operands, R=0 (N+1 bits), Q=dividendo,
//     cnt=N-1, busy=1.
//   - divisor==0: go straight to DONE, set div_cero=1.
//   - otherwise go to CALC.
//  CALC, each edge:
//   - S = {R[N-1:0], Q[N-1]} + {1'b1, ~D} + 1 (N+1 bits, carry out dropped).
//   - S[N]==0: R=S, shift Q left inserting 1.
//   - else: R = shifted value, shift Q left inserting 0.
//   - cnt==0 -> DONE, else cnt--. Exactly N CALC cycles.
//  DONE (one cycle):
//   - done=1; cociente=Q, residuo=R[N-1:0], busy=0 on the next edge.
//   - Return to IDLE.
//  Div by zero: cociente={N{1'b1}}, residuo=dividendo, div_cero=1.
//  Latency: done is high in the cycle after edge k+N+1, or after edge k+1
//   when divisor==0. Outputs change only on the DONE edge.
//  start while busy=1 (CALC or DONE) is ignored; it is not queued.
//  start in the same cycle done=1 is ignored; start is accepted from IDLE
//   only, so the earliest new start is the cycle after done.
//  Result invariant when div_cero=0: dividendo == cociente*divisor + residuo,
//   with residuo < divisor.
//  No combinational path from inputs to outputs; all outputs registered.
// STRUCTURE
//  Package divisor_pkg holds:
//   - typedef enum logic [1:0] {IDLE, CALC, DONE} estado_t
//   - localparam helper for counter width: $clog2(N)
//  Sub-module restador #(N+1): combinational a - b.
//   - Built as a sumador plus a two's-complement negation of b.
//   - Outputs the difference and a borrow flag (borrow = MSB of result).
//  Top level holds the FSM, R/Q/D/cnt registers and output registers.
// TESTING
//  N=4, start with 13/4 -> done 6 cycles after the start edge; cociente=3,
//   residuo=1, div_cero=0.
//  N=4, 15/1 -> cociente=15, residuo=0; 3/7 -> cociente=0, residuo=3.
//  N=4, 9/0 -> done 2 cycles after start; cociente=4'hF, residuo=9,
//   div_cero=1.
//  start pulsed in every cycle of a 13/4 run -> only the first is accepted;
//   exactly one done; result 3 r1.
//  rst_n=0 asserted during the 3rd CALC cycle -> all outputs 0 immediately
//   (async), no done pulse; a new 6/2 afterwards yields 3 r0.
//  N=8 random sweep of 1000 pairs against a reference model, checking the
//   invariant; every done is exactly one cycle wide.

Source files
------------

// File: rtl/divisor_pkg.sv
// Shared definitions for the sequential restoring divider.
//   estado_t  : FSM encoding IDLE -> CALC -> DONE -> IDLE
//   ancho_cnt : bit-count counter width for an n-bit operand ($clog2(n), min 1)
package divisor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } estado_t;

    localparam int unsigned N_DEFECTO = 4;

    function automatic int unsigned ancho_cnt(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned CNT_W_DEFECTO = ancho_cnt(N_DEFECTO);

endpackage

// File: rtl/divisor_secuencial_restador.sv
// Combinational W-bit subtractor a - b, built as an adder fed with the
// two's-complement negation of b (~b + 1).
//   a, b        : W-bit operands
//   diferencia  : a - b modulo 2^W
//   borrow      : MSB of the difference (1 when a < b for in-range operands)
module restador #(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diferencia,
    output logic         borrow
);

    logic [W-1:0] b_neg;

    always_comb begin
        b_neg      = ~b + W'(1);
        diferencia = a + b_neg;
        borrow     = diferencia[W-1];
    end

endmodule

// File: rtl/divisor_secuencial.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
//   clk, rst_n          : rising-edge clock, async active-low reset
//   start               : request, accepted in IDLE only
//   dividendo, divisor  : N-bit operands captured on the accepted start
//   busy                : high from accepted start until the DONE edge
//   done                : one-cycle result-valid pulse
//   cociente, residuo   : result, held until the next result
//   div_cero            : divisor was zero (cociente all ones, residuo = dividend)
module divisor_secuencial #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividendo,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] cociente,
    output logic [N-1:0] residuo,
    output logic         div_cero
);

    import divisor_pkg::*;

    localparam int unsigned CW = ancho_cnt(N);

    estado_t        estado_q, estado_d;
    logic [N:0]     r_q, r_d;
    logic [N-1:0]   q_q, q_d;
    logic [N-1:0]   d_q, d_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           cero_q, cero_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [N-1:0]   cociente_q, cociente_d;
    logic [N-1:0]   residuo_q, residuo_d;
    logic           div_cero_q, div_cero_d;

    logic [N:0]     desplazado;
    logic [N:0]     diferencia;
    logic           borrow;

    assign desplazado = {r_q[N-1:0], q_q[N-1]};

    restador #(.W(N + 1)) u_restador (
        .a          (desplazado),
        .b          ({1'b0, d_q}),
        .diferencia (diferencia),
        .borrow     (borrow)
    );

    always_comb begin
        estado_d   = estado_q;
        r_d        = r_q;
        q_d        = q_q;
        d_d        = d_q;
        cnt_d      = cnt_q;
        cero_d     = cero_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cociente_d = cociente_q;
        residuo_d  = residuo_q;
        div_cero_d = div_cero_q;

        unique case (estado_q)
            IDLE: begin
                // The FSM is already back in IDLE during the done cycle;
                // a start seen there must still be ignored.
                if (start && !done_q) begin
                    d_d      = divisor;
                    q_d      = dividendo;
                    r_d      = '0;
                    cnt_d    = CW'(N - 1);
                    busy_d   = 1'b1;
                    cero_d   = (divisor == '0);
                    estado_d = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (!borrow) begin
                    r_d = diferencia;
                    q_d = {q_q[N-2:0], 1'b1};
                end else begin
                    r_d = desplazado;
                    q_d = {q_q[N-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    estado_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                done_d     = 1'b1;
                busy_d     = 1'b0;
                div_cero_d = cero_q;
                if (cero_q) begin
                    // Q still holds the untouched dividend.
                    cociente_d = '1;
                    residuo_d  = q_q;
                end else begin
                    cociente_d = q_q;
                    residuo_d  = r_q[N-1:0];
                end
                estado_d = IDLE;
            end
            default: estado_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q   <= IDLE;
            r_q        <= '0;
            q_q        <= '0;
            d_q        <= '0;
            cnt_q      <= '0;
            cero_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cociente_q <= '0;
            residuo_q  <= '0;
            div_cero_q <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            r_q        <= r_d;
            q_q        <= q_d;
            d_q        <= d_d;
            cnt_q      <= cnt_d;
            cero_q     <= cero_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cociente_q <= cociente_d;
            residuo_q  <= residuo_d;
            div_cero_q <= div_cero_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign cociente = cociente_q;
    assign residuo  = residuo_q;
    assign div_cero = div_cero_q;

endmodule
